spi_master_arb: RTL and testbench

- Round-robin arbiter plus SPI master sequencer. Shares one SPI bus (Sck/Mosi/Miso/Ss) between NREQ local requesters.
- Generates mode-0 serial clocking, slave selects and 8-bit MSB-first byte transfers. Supports multi-byte bursts under one continuous slave select.
- Sits on the master side of the bus that drives the team's byte-oriented SPI slaves. Those slaves select on active-high ss and sample on synchronised sck rising edges.

---
 rtl/spi_master_arb.sv | 246 ++++++++++++++++++++++++
 tb/tb_spi_master_arb.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arb.sv
// Round-robin arbiter sharing one mode-0 SPI bus between NREQ requesters.
// Byte-wide MSB-first transfers, multi-byte bursts under one slave select.
module spi_master_arb #(
    parameter int NREQ   = 2,
    parameter int NSLV   = 4,
    parameter int SW     = $clog2(NSLV),
    parameter int CLKDIV = 4
) (
    input  logic              Clk_i,
    input  logic              Rst_ni,
    input  logic [NREQ-1:0]   Req_i,
    input  logic [NREQ*SW-1:0] Slv_i,
    input  logic [NREQ*8-1:0] TxData_i,
    input  logic [NREQ-1:0]   Last_i,
    output logic [NREQ-1:0]   Gnt_o,
    output logic [NREQ-1:0]   ByteDone_o,
    output logic [7:0]        RxData_o,
    output logic              Busy_o,
    output logic              Sck_o,
    output logic              Mosi_o,
    input  logic              Miso_i,
    output logic [NSLV-1:0]   Ss_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DW = $clog2(2 * CLKDIV);
    localparam logic [DW-1:0] HALF_LAST = DW'(CLKDIV - 1);
    localparam logic [DW-1:0] OFF_LAST  = DW'(2 * CLKDIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        SSOFF
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [DW-1:0]   div_q, div_d;
    logic [2:0]      bit_q, bit_d;
    logic [6:0]      tx_q, tx_d;
    logic [7:0]      rx_q, rx_d;
    logic [7:0]      rxd_q, rxd_d;
    logic            last_q, last_d;
    logic            sck_q, sck_d;
    logic            mosi_q, mosi_d;
    logic [NSLV-1:0] ss_q, ss_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] bd_q, bd_d;
    logic            busy_q, busy_d;

    logic            any_req;
    logic [IW-1:0]   win;
    logic [SW-1:0]   win_slv;
    logic [NSLV-1:0] win_ss;

    // Requester index k positions after the pointer, wrapping at NREQ.
    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] p,
                                             input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IW'(s);
    endfunction

    // Round-robin pick: first requester at or after the pointer.
    always_comb begin
        any_req = 1'b0;
        win     = ptr_q;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (Req_i[rr_idx(ptr_q, k)]) begin
                any_req = 1'b1;
                win     = rr_idx(ptr_q, k);
            end
        end
    end

    // Decode the winner's slave index; out-of-range selects nothing.
    always_comb begin
        win_slv = Slv_i[int'(win)*SW +: SW];
        win_ss  = '0;
        for (int j = 0; j < NSLV; j++) begin
            if (int'(win_slv) == j) begin
                win_ss[j] = 1'b1;
            end
        end
    end

    // Next-state and datapath updates for the bus sequencer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        div_d   = div_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rxd_d   = rxd_q;
        last_d  = last_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        ss_d    = ss_q;
        gnt_d   = gnt_q;
        bd_d    = '0;
        busy_d  = busy_q;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d     = SETUP;
                    gidx_d      = win;
                    gnt_d       = '0;
                    gnt_d[win]  = 1'b1;
                    ss_d        = win_ss;
                    busy_d      = 1'b1;
                    div_d       = '0;
                end
            end

            SETUP: begin
                sck_d = 1'b0;
                if (div_q == '0) begin
                    if (!Req_i[gidx_q]) begin
                        state_d = SSOFF;
                        ss_d    = '0;
                        div_d   = '0;
                    end else begin
                        tx_d   = TxData_i[int'(gidx_q)*8 +: 7];
                        mosi_d = TxData_i[int'(gidx_q)*8 + 7];
                        last_d = Last_i[gidx_q];
                        div_d  = div_q + DW'(1);
                    end
                end else if (div_q == HALF_LAST) begin
                    state_d = SHIFT;
                    div_d   = '0;
                    bit_d   = '0;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end

            SHIFT: begin
                if (div_q == HALF_LAST) begin
                    div_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        rx_d  = {rx_q[6:0], Miso_i};
                    end else begin
                        sck_d  = 1'b0;
                        tx_d   = {tx_q[5:0], 1'b0};
                        mosi_d = tx_q[6];
                        bit_d  = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            rxd_d        = rx_q;
                            bd_d[gidx_q] = 1'b1;
                            if (last_q) begin
                                state_d = SSOFF;
                                ss_d    = '0;
                            end else begin
                                state_d = SETUP;
                            end
                        end
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end

            SSOFF: begin
                sck_d = 1'b0;
                ss_d  = '0;
                if (div_q == OFF_LAST) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    div_d   = '0;
                    if (int'(gidx_q) == NREQ - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = gidx_q + IW'(1);
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            ptr_q  <= '0;
            gidx_q <= '0;
            div_q  <= '0;
            bit_q  <= '0;
            tx_q   <= '0;
            rx_q   <= '0;
            rxd_q  <= '0;
            last_q <= 1'b0;
            sck_q  <= 1'b0;
            mosi_q <= 1'b0;
            ss_q   <= '0;
            gnt_q  <= '0;
            bd_q   <= '0;
            busy_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            gidx_q <= gidx_d;
            div_q  <= div_d;
            bit_q  <= bit_d;
            tx_q   <= tx_d;
            rx_q   <= rx_d;
            rxd_q  <= rxd_d;
            last_q <= last_d;
            sck_q  <= sck_d;
            mosi_q <= mosi_d;
            ss_q   <= ss_d;
            gnt_q  <= gnt_d;
            bd_q   <= bd_d;
            busy_q <= busy_d;
        end
    end

    assign Gnt_o      = gnt_q;
    assign ByteDone_o = bd_q;
    assign RxData_o   = rxd_q;
    assign Busy_o     = busy_q;
    assign Sck_o      = sck_q;
    assign Mosi_o     = mosi_q;
    assign Ss_o       = ss_q;

endmodule

// File: tb/tb_spi_master_arb.sv
// Bench for spi_master_arb: directed plan plus random bursts against
// a transaction-level model of arbitration, framing and byte timing.
module tb_spi_master_arb;

    localparam int NREQ = 2;
    localparam int NSLV = 4;
    localparam int SW   = 3;
    localparam int C    = 4;

    logic                Clk_i  = 1'b0;
    logic                Rst_ni = 1'b1;
    logic [NREQ-1:0]     Req_i  = '0;
    logic [NREQ*SW-1:0]  Slv_i  = '0;
    logic [NREQ*8-1:0]   TxData_i = '0;
    logic [NREQ-1:0]     Last_i = '0;
    logic [NREQ-1:0]     Gnt_o;
    logic [NREQ-1:0]     ByteDone_o;
    logic [7:0]          RxData_o;
    logic                Busy_o;
    logic                Sck_o;
    logic                Mosi_o;
    logic                Miso_i = 1'b0;
    logic [NSLV-1:0]     Ss_o;

    spi_master_arb #(
        .NREQ  (NREQ),
        .NSLV  (NSLV),
        .SW    (SW),
        .CLKDIV(C)
    ) dut (
        .Clk_i     (Clk_i),
        .Rst_ni    (Rst_ni),
        .Req_i     (Req_i),
        .Slv_i     (Slv_i),
        .TxData_i  (TxData_i),
        .Last_i    (Last_i),
        .Gnt_o     (Gnt_o),
        .ByteDone_o(ByteDone_o),
        .RxData_o  (RxData_o),
        .Busy_o    (Busy_o),
        .Sck_o     (Sck_o),
        .Mosi_o    (Mosi_o),
        .Miso_i    (Miso_i),
        .Ss_o      (Ss_o)
    );

    always #5 Clk_i = ~Clk_i;

    int n_chk  = 0;
    int n_pass = 0;

    int            ptr;
    logic [7:0]    tx_t [NREQ][4];
    logic [SW-1:0] slv_t [NREQ];
    logic [7:0]    sb [4];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic burst(input logic [NREQ-1:0] mask, input int n,
                         input bit abort, input bit keep, output int w);
        int cyc, rises, bds, sshi, busyc, gbad, ssbad, hibad, hicnt;
        int first_rise, last_bd, exp_busy;
        logic psck;
        logic [7:0] mos;
        logic [NSLV-1:0] ess;
        logic [NREQ-1:0] eg;
        w = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (w < 0 && mask[(ptr + i) % NREQ]) w = (ptr + i) % NREQ;
        end
        eg = '0;
        eg[w] = 1'b1;
        ess = '0;
        if (int'(slv_t[w]) < NSLV) ess[slv_t[w]] = 1'b1;
        for (int r = 0; r < NREQ; r++) begin
            Slv_i[r*SW +: SW]  = slv_t[r];
            TxData_i[r*8 +: 8] = tx_t[r][0];
            Last_i[r]          = (n == 1);
        end
        Req_i  = mask;
        Miso_i = sb[0][7];
        cyc = 0; rises = 0; bds = 0; sshi = 0; busyc = 0;
        gbad = 0; ssbad = 0; hibad = 0; hicnt = 0;
        first_rise = 0; last_bd = 0; psck = 1'b0; mos = '0;
        forever begin
            @(negedge Clk_i);
            cyc++;
            if (cyc > 400) begin
                chk("burst_timeout", cyc, 0);
                break;
            end
            if (!Busy_o) break;
            busyc++;
            if (Gnt_o !== eg) gbad++;
            if (Ss_o !== '0) begin
                sshi++;
                if (Ss_o !== ess) ssbad++;
            end
            if (abort && cyc == 1) Req_i[w] = 1'b0;
            if (Sck_o && !psck) begin
                rises++;
                if (rises == 1) first_rise = cyc;
                mos   = {mos[6:0], Mosi_o};
                hicnt = 0;
            end
            if (Sck_o) hicnt++;
            if (!Sck_o && psck) begin
                if (hicnt != C) hibad++;
                Miso_i = sb[(rises / 8) % 4][7 - (rises % 8)];
            end
            psck = Sck_o;
            if (ByteDone_o !== '0) begin
                chk("bytedone_onehot", ByteDone_o, eg);
                chk("rxdata", RxData_o, sb[bds % 4]);
                chk("mosi_byte", mos, tx_t[w][bds % 4]);
                if (bds > 0) chk("bytedone_gap", cyc - last_bd, 17 * C);
                last_bd = cyc;
                bds++;
                if (bds < n) begin
                    TxData_i[w*8 +: 8] = tx_t[w][bds];
                    Last_i[w]          = (bds == n - 1);
                end else if (!keep) begin
                    Req_i[w] = 1'b0;
                end
            end
        end
        exp_busy = abort ? 1 + 2 * C : n * 17 * C + 2 * C;
        chk("busy_cycles", busyc, exp_busy);
        chk("sck_rises", rises, abort ? 0 : 8 * n);
        chk("bytedones", bds, abort ? 0 : n);
        chk("ss_high_cycles", sshi, (ess == '0) ? 0 : (abort ? 1 : n * 17 * C));
        chk("ss_pattern_bad", ssbad, 0);
        chk("gnt_bad", gbad, 0);
        chk("sck_high_bad", hibad, 0);
        if (!abort) begin
            chk("first_rise", first_rise, 1 + 2 * C);
            chk("ssoff_len", cyc - last_bd, 2 * C);
        end
        chk("idle_gnt", Gnt_o, 0);
        chk("idle_ss", Ss_o, 0);
        chk("idle_sck", Sck_o, 0);
        ptr = (w + 1) % NREQ;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w, wp, rises;
        logic ps;
        ptr = 0;
        for (int r = 0; r < NREQ; r++) begin
            slv_t[r] = '0;
            for (int k = 0; k < 4; k++) tx_t[r][k] = '0;
        end
        for (int k = 0; k < 4; k++) sb[k] = '0;

        #2 Rst_ni = 1'b0;
        #1;
        chk("rst_sck", Sck_o, 0);
        chk("rst_mosi", Mosi_o, 0);
        chk("rst_ss", Ss_o, 0);
        chk("rst_gnt", Gnt_o, 0);
        chk("rst_bd", ByteDone_o, 0);
        chk("rst_busy", Busy_o, 0);
        chk("rst_rx", RxData_o, 0);
        repeat (3) @(negedge Clk_i);
        Rst_ni = 1'b1;
        @(negedge Clk_i);

        tx_t[0][0] = 8'hA5; slv_t[0] = 3'd2; sb[0] = 8'h3C;
        burst(2'b01, 1, 1'b0, 1'b0, w);
        chk("single_winner", w, 0);

        tx_t[1][0] = 8'h11; tx_t[1][1] = 8'h22; tx_t[1][2] = 8'h33;
        slv_t[1] = 3'd1;
        sb[0] = 8'h5A; sb[1] = 8'hC3; sb[2] = 8'h96;
        burst(2'b10, 3, 1'b0, 1'b0, w);
        chk("burst_winner", w, 1);

        tx_t[0][0] = 8'h81; tx_t[1][0] = 8'h7E;
        slv_t[0] = 3'd0; slv_t[1] = 3'd3;
        sb[0] = 8'hE7;
        wp = 1;
        for (int i = 0; i < 4; i++) begin
            burst(2'b11, 1, 1'b0, 1'b1, w);
            chk("contention_alt", w, 1 - wp);
            wp = w;
        end
        Req_i = '0;

        burst(2'b01, 1, 1'b1, 1'b0, w);
        chk("abort_winner", w, 0);

        slv_t[0] = 3'd5; tx_t[0][0] = 8'h5C; sb[0] = 8'hA9;
        burst(2'b01, 1, 1'b0, 1'b0, w);

        for (int it = 0; it < 12; it++) begin
            for (int r = 0; r < NREQ; r++) begin
                slv_t[r] = SW'($urandom_range(0, 7));
                for (int k = 0; k < 4; k++) tx_t[r][k] = 8'($urandom);
            end
            for (int k = 0; k < 4; k++) sb[k] = 8'($urandom);
            burst(NREQ'($urandom_range(1, 3)), $urandom_range(1, 3),
                  ($urandom_range(0, 5) == 0), 1'b0, w);
        end
        Req_i = '0;

        slv_t[0] = 3'd1; tx_t[0][0] = 8'h3F; sb[0] = 8'h42;
        burst(2'b01, 1, 1'b0, 1'b0, w);

        Slv_i[0 +: SW]  = 3'd2;
        TxData_i[0 +: 8] = 8'hC6;
        Last_i[0] = 1'b1;
        Miso_i = 1'b1;
        Req_i = 2'b01;
        rises = 0;
        ps = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge Clk_i);
            if (Sck_o && !ps) rises++;
            ps = Sck_o;
            if (rises == 5) break;
        end
        chk("reset_reached_bit4", rises, 5);
        #2 Rst_ni = 1'b0;
        #1;
        chk("midrst_sck", Sck_o, 0);
        chk("midrst_ss", Ss_o, 0);
        chk("midrst_gnt", Gnt_o, 0);
        chk("midrst_busy", Busy_o, 0);
        Req_i = '0;
        ptr = 0;
        @(negedge Clk_i);
        Rst_ni = 1'b1;
        @(negedge Clk_i);

        slv_t[0] = 3'd2; tx_t[0][0] = 8'hB4;
        slv_t[1] = 3'd0; tx_t[1][0] = 8'h0F;
        sb[0] = 8'hD2;
        burst(2'b11, 1, 1'b0, 1'b0, w);
        chk("post_reset_winner", w, 0);
        Req_i = '0;
        repeat (2) @(negedge Clk_i);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
